timer_arbiter: RTL and testbench

Shares one 32-bit countdown timer between NREQ requesters so several control loops can schedule one-shot delays without each instantiating its own counter. A requester raises `req` with a delay value. The block grants the timer round-robin, counts the delay down in `timer_tick` units, then pulses `done` to the owner. It sits between the timing consumers, such as lock sequencers and sweep steppers, and the common tick prescaler.

---
 rtl/timer_arbiter_if.sv | 31 +++
 rtl/timer_arbiter.sv | 122 ++++++++++++
 tb/tb_timer_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_arbiter_if.sv
// Request/grant bundle between the timing consumers and the shared countdown timer.
// Requesters drive req/delay; the arbiter returns ownership, completion and counter state.
interface timer_arbiter_if #(
    parameter int NREQ = 4,
    parameter int CW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] delay;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [CW-1:0]      remaining;

    modport master (
        output req,
        output delay,
        input  grant,
        input  done,
        input  busy,
        input  remaining
    );

    modport slave (
        input  req,
        input  delay,
        output grant,
        output done,
        output busy,
        output remaining
    );
endinterface

// File: rtl/timer_arbiter.sv
// One shared 32-bit countdown timer handed out round-robin to NREQ requesters;
// the owner gets a one-cycle done pulse when its delay has elapsed in timer_tick units.
module timer_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                timer_tick,
    timer_arbiter_if.slave      bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t          state_reg;
    logic [IW-1:0]   owner_reg;
    logic [IW-1:0]   rr_ptr_reg;
    logic [NREQ-1:0] grant_reg;
    logic [NREQ-1:0] done_reg;
    logic            busy_reg;
    logic [CW-1:0]   remaining_reg;

    logic [IW-1:0]   sel_idx;
    logic            sel_found;
    logic [IW-1:0]   next_ptr;
    logic [CW-1:0]   delay_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_delay
            assign delay_arr[gi] = bus.delay[gi*CW +: CW];
        end
    endgenerate

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First set request at or after rr_ptr, wrapping NREQ-1 -> 0.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            logic [IW:0] cand;
            cand = {1'b0, rr_ptr_reg} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!sel_found && bus.req[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
    end

    assign next_ptr = (owner_reg == IW'(NREQ-1)) ? '0 : owner_reg + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            grant_reg     <= '0;
            done_reg      <= '0;
            busy_reg      <= 1'b0;
            remaining_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= '0;
                    if (sel_found) begin
                        owner_reg     <= sel_idx;
                        remaining_reg <= delay_arr[sel_idx];
                        grant_reg     <= onehot(sel_idx);
                        busy_reg      <= 1'b1;
                        state_reg     <= COUNT;
                    end
                end
                COUNT: begin
                    // Owner dropping its request beats a coincident final tick.
                    if (!bus.req[owner_reg]) begin
                        grant_reg     <= '0;
                        remaining_reg <= '0;
                        busy_reg      <= 1'b0;
                        rr_ptr_reg    <= next_ptr;
                        state_reg     <= IDLE;
                    end else if (remaining_reg == '0) begin
                        done_reg  <= onehot(owner_reg);
                        state_reg <= DONE;
                    end else if (timer_tick) begin
                        if (remaining_reg == CW'(1)) begin
                            remaining_reg <= '0;
                            done_reg      <= onehot(owner_reg);
                            state_reg     <= DONE;
                        end else begin
                            remaining_reg <= remaining_reg - 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_reg   <= '0;
                    grant_reg  <= '0;
                    busy_reg   <= 1'b0;
                    rr_ptr_reg <= next_ptr;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = grant_reg;
    assign bus.done      = done_reg;
    assign bus.busy      = busy_reg;
    assign bus.remaining = remaining_reg;
endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: scenario tasks push expected done pulses to a queue,
// and a monitor pops and compares them whenever the DUT raises done.
module tb_timer_arbiter;
    localparam int NREQ = 4;
    localparam int CW   = 32;

    logic clk;
    logic rstn;
    logic timer_tick;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic [NREQ-1:0] vec;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];

    timer_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

    timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .timer_tick (timer_tick),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done pulse must match the next expected entry.
    always begin
        @(posedge clk);
        #1;
        if (bus.done !== '0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done=%b at cycle %0d, wanted no done", bus.done, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.done !== e.vec || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL done_pulse: got done=%b at cycle %0d, wanted %b at cycle %0d",
                             bus.done, cyc, e.vec, e.cyc);
                end
            end
            n_checks++;
            if (bus.grant !== bus.done) begin
                n_fail++;
                $display("FAIL grant_during_done: got grant=%b, wanted %b", bus.grant, bus.done);
            end
        end
    end

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req    = 4'($urandom);
            bus.delay  = {$urandom, $urandom, $urandom, $urandom};
            timer_tick = 1'($urandom);
            step();
            n_checks += 4;
            if (bus.grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b, wanted 0", bus.grant); end
            if (bus.done !== '0) begin n_fail++; $display("FAIL reset_done: got %b, wanted 0", bus.done); end
            if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, wanted 0", bus.busy); end
            if (bus.remaining !== '0) begin n_fail++; $display("FAIL reset_remaining: got %0d, wanted 0", bus.remaining); end
        end
        bus.req    = '0;
        timer_tick = 1'b0;
        rstn       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks += 2;
            if (bus.grant !== '0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle: got grant=%b busy=%b, wanted 0 0", bus.grant, bus.busy);
            end
            if (bus.remaining !== '0) begin n_fail++; $display("FAIL post_reset_remaining: got %0d, wanted 0", bus.remaining); end
        end
    endtask

    task automatic test_single();
        bus.delay           = '0;
        bus.delay[2*CW +: CW] = 32'd3;
        bus.req             = 4'b0100;
        timer_tick          = 1'b1;
        step();
        exp_q.push_back('{vec: 4'b0100, cyc: cyc + 3});
        n_checks += 3;
        if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b, wanted 0100", bus.grant); end
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b, wanted 1", bus.busy); end
        if (bus.remaining !== 32'd3) begin n_fail++; $display("FAIL single_load: got %0d, wanted 3", bus.remaining); end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++;
            if (bus.remaining !== 32'(3 - i)) begin
                n_fail++;
                $display("FAIL single_count: got %0d, wanted %0d", bus.remaining, 3 - i);
            end
        end
        bus.req = '0;
        step();
        step();
        n_checks += 2;
        if (bus.busy !== 1'b0 || bus.grant !== '0) begin
            n_fail++;
            $display("FAIL single_release: got busy=%b grant=%b, wanted 0 0000", bus.busy, bus.grant);
        end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_done_missing: got %0d pending, wanted 0", exp_q.size()); end
    endtask

    task automatic test_zero_delay();
        bus.delay  = '0;
        bus.req    = 4'b0001;
        timer_tick = 1'b0;
        step();
        exp_q.push_back('{vec: 4'b0001, cyc: cyc + 1});
        n_checks += 2;
        if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL zero_grant: got %b, wanted 0001", bus.grant); end
        if (bus.remaining !== '0) begin n_fail++; $display("FAIL zero_load: got %0d, wanted 0", bus.remaining); end
        step();
        bus.req = '0;
        step();
        step();
        n_checks += 2;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b, wanted 0", bus.busy); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL zero_done_missing: got %0d pending, wanted 0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        int cyc_k;
        logic [NREQ-1:0] want;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        for (int j = 0; j < NREQ; j++) bus.delay[j*CW +: CW] = 32'd1;
        bus.req    = 4'b1111;
        timer_tick = 1'b1;
        step();
        cyc_k = cyc;
        for (int j = 0; j < 5; j++) begin
            exp_q.push_back('{vec: 4'(1 << (j % NREQ)), cyc: cyc_k + 3*j + 1});
        end
        for (int i = 0; i < 14; i++) begin
            want = (i % 3 == 2) ? 4'b0000 : 4'(1 << ((i / 3) % NREQ));
            n_checks++;
            if (bus.grant !== want) begin
                n_fail++;
                $display("FAIL rr_grant: got %b at offset %0d, wanted %b", bus.grant, i, want);
            end
            if (i == 13) bus.req = '0;
            step();
        end
        step();
        n_checks += 2;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy: got %b, wanted 0", bus.busy); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_done_missing: got %0d pending, wanted 0", exp_q.size()); end
    endtask

    task automatic test_tick_gating();
        int ticks;
        bus.delay             = '0;
        bus.delay[1*CW +: CW] = 32'd5;
        bus.req               = 4'b0010;
        timer_tick            = 1'b0;
        step();
        exp_q.push_back('{vec: 4'b0010, cyc: cyc + 20});
        n_checks++;
        if (bus.grant !== 4'b0010 || bus.remaining !== 32'd5) begin
            n_fail++;
            $display("FAIL gate_grant: got grant=%b rem=%0d, wanted 0010 5", bus.grant, bus.remaining);
        end
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            timer_tick = (i % 4 == 3);
            step();
            if (timer_tick) ticks++;
            n_checks++;
            if (bus.remaining !== 32'(5 - ticks)) begin
                n_fail++;
                $display("FAIL gate_count: got %0d at offset %0d, wanted %0d", bus.remaining, i + 1, 5 - ticks);
            end
        end
        timer_tick = 1'b0;
        bus.req    = '0;
        step();
        step();
        n_checks += 2;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL gate_busy: got %b, wanted 0", bus.busy); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL gate_done_missing: got %0d pending, wanted 0", exp_q.size()); end
    endtask

    task automatic test_abort();
        int ticks;
        bus.delay             = '0;
        bus.delay[3*CW +: CW] = 32'd5;
        bus.req               = 4'b1000;
        timer_tick            = 1'b0;
        step();
        n_checks++;
        if (bus.grant !== 4'b1000) begin n_fail++; $display("FAIL abort_grant: got %b, wanted 1000", bus.grant); end
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            timer_tick = (i % 4 == 3);
            step();
            if (timer_tick) ticks++;
        end
        n_checks++;
        if (bus.remaining !== 32'(5 - ticks)) begin n_fail++; $display("FAIL abort_pre: got %0d, wanted %0d", bus.remaining, 5 - ticks); end
        bus.req    = '0;
        timer_tick = 1'b0;
        step();
        n_checks++;
        if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.remaining !== '0) begin
            n_fail++;
            $display("FAIL abort_clear: got grant=%b busy=%b rem=%0d, wanted 0000 0 0", bus.grant, bus.busy, bus.remaining);
        end
        for (int j = 0; j < NREQ; j++) bus.delay[j*CW +: CW] = 32'd1;
        bus.req = 4'b1111;
        step();
        n_checks++;
        if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL abort_next_owner: got %b, wanted 0001", bus.grant); end
        // Final tick and abort in the same cycle: no done may follow.
        bus.req    = '0;
        timer_tick = 1'b1;
        step();
        timer_tick = 1'b0;
        n_checks++;
        if (bus.grant !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_vs_tick: got grant=%b busy=%b, wanted 0000 0", bus.grant, bus.busy);
        end
        step();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_queue: got %0d pending, wanted 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_count();
        int budget;
        bus.delay             = '0;
        bus.delay[1*CW +: CW] = 32'd10;
        bus.req               = 4'b0010;
        timer_tick            = 1'b1;
        step();
        n_checks++;
        if (bus.remaining !== 32'd10) begin n_fail++; $display("FAIL mid_load: got %0d, wanted 10", bus.remaining); end
        step();
        step();
        step();
        n_checks++;
        if (bus.remaining !== 32'd7) begin n_fail++; $display("FAIL mid_pre: got %0d, wanted 7", bus.remaining); end
        #2;
        rstn = 1'b0;
        #1;
        n_checks += 4;
        if (bus.grant !== '0) begin n_fail++; $display("FAIL mid_reset_grant: got %b, wanted 0", bus.grant); end
        if (bus.done !== '0) begin n_fail++; $display("FAIL mid_reset_done: got %b, wanted 0", bus.done); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b, wanted 0", bus.busy); end
        if (bus.remaining !== '0) begin n_fail++; $display("FAIL mid_reset_remaining: got %0d, wanted 0", bus.remaining); end
        step();
        step();
        rstn = 1'b1;
        step();
        n_checks++;
        if (bus.grant !== 4'b0010 || bus.remaining !== 32'd10) begin
            n_fail++;
            $display("FAIL mid_restart: got grant=%b rem=%0d, wanted 0010 10", bus.grant, bus.remaining);
        end
        exp_q.push_back('{vec: 4'b0010, cyc: cyc + 10});
        budget = 30;
        while (exp_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        bus.req    = '0;
        timer_tick = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_done_timeout: got %0d pending, wanted 0", exp_q.size()); end
        step();
        step();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rstn       = 1'b0;
        bus.req    = '0;
        bus.delay  = '0;
        timer_tick = 1'b0;
        test_reset();
        test_single();
        test_zero_delay();
        test_round_robin();
        test_tick_gating();
        test_abort();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, wanted completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
